// File: rtl/cpuex_def_h.sv
// Shared CPU exception definitions and default fetch address map.
package cpuex_def_h;

  localparam logic [4:0] EXC_NONE = 5'h0;
  localparam logic [4:0] EXC_ADEL = 5'h4;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] DEF_ADDR_LO  = 32'h0000_3000;
  localparam logic [31:0] DEF_ADDR_HI  = 32'h0000_6ffc;

  // Fetch address error check: word aligned and inside [lo, hi], unsigned.
  function automatic logic [4:0] classify_pc(input logic [31:0] pc,
                                             input logic [31:0] lo,
                                             input logic [31:0] hi);
    if (pc[1:0] == 2'b00 && pc >= lo && pc <= hi) return EXC_NONE;
    return EXC_ADEL;
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// Generic synchronous FIFO with push/pop/flush and occupancy count.
// The head data is kept in its own register so that it holds the last
// value once the FIFO drains and never depends combinationally on pop.
module fq_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop_ok, push_ok;
  logic [CW-1:0]    remain;

  // Next-state for pointers, occupancy and registered head entry.
  always_comb begin
    pop_ok   = pop && (cnt_q != '0);
    push_ok  = push && ((cnt_q != FULL_CNT) || pop_ok);
    remain   = cnt_q - (pop_ok ? CW'(1) : CW'(0));
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    head_d   = head_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = remain + (push_ok ? CW'(1) : CW'(0));
      // Older entries stay ahead of the pushed one; an empty FIFO takes
      // the pushed data straight into the head register.
      if (remain != '0)  head_d = mem_q[rd_ptr_d];
      else if (push_ok)  head_d = push_data;
    end
  end

  // Storage write; no reset needed since entries are qualified by count.
  always_ff @(posedge clk) begin
    if (!flush && push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  assign out_valid = (cnt_q != '0);
  assign out_data  = head_q;
  assign count     = cnt_q;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch-address unit: sequential PC generation, interrupt/branch redirect,
// fetch address error classification and a PC/exception queue to decode.
// Optional performance counters are built when IFU_FQ_PERF_EN is defined.
// Handshake: an entry moves to decode on a cycle where out_valid and
// out_ready are both high; out_valid/out_pc/out_exc never depend on out_ready.
module ifu_fetch_queue import cpuex_def_h::*; #(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_PC   = DEF_EXC_PC,
  parameter logic [31:0] ADDR_LO  = DEF_ADDR_LO,
  parameter logic [31:0] ADDR_HI  = DEF_ADDR_HI,
  parameter int          DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   int_req,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [31:0]            fetch_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [4:0]             out_exc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   fsm_state
`ifdef IFU_FQ_PERF_EN
  ,
  output logic [31:0]            perf_full_cycles,
  output logic [31:0]            perf_flushes
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} fq_state_e;

  fq_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush, pop, push;
  logic [31:0] flush_target;
  logic [4:0]  pc_exc;
  logic [36:0] head_data;

  // Redirect selection, push enable, PC update and RUN/FAULT transitions.
  always_comb begin
    flush        = int_req || redirect_valid;
    flush_target = int_req ? EXC_PC : redirect_pc;
    pop          = out_valid && out_ready;
    pc_exc       = classify_pc(pc_q, ADDR_LO, ADDR_HI);
    push         = 1'b0;
    pc_d         = pc_q;
    state_d      = state_q;
    if (flush) begin
      pc_d    = flush_target;
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && (count != FULL_CNT || pop)) begin
      push = 1'b1;
      pc_d = pc_q + 32'd4;
      if (pc_exc != EXC_NONE) state_d = ST_FAULT;
    end
  end

  // PC and FSM state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fq_fifo #(.WIDTH(37), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({pc_q, pc_exc}),
    .pop       (pop),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (head_data),
    .count     (count)
  );

  assign fetch_pc  = pc_q;
  assign out_pc    = head_data[36:5];
  assign out_exc   = head_data[4:0];
  assign fsm_state = state_q;

`ifdef IFU_FQ_PERF_EN
  logic [31:0] perf_full_q, perf_full_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Full-stall cycle and flush event counters, wrapping at 2^32.
  always_comb begin
    perf_full_d  = perf_full_q;
    perf_flush_d = perf_flush_q;
    if (count == FULL_CNT && !pop) perf_full_d = perf_full_q + 32'd1;
    if (flush) perf_flush_d = perf_flush_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_full_q  <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_full_q  <= perf_full_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_full_cycles = perf_full_q;
  assign perf_flushes     = perf_flush_q;
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed testbench for ifu_fetch_queue (perf counters checked when
// IFU_FQ_PERF_EN is defined).
module tb_ifu_fetch_queue;

  logic        clk;
  logic        reset;
  logic        int_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_exc;
  logic [2:0]  count;
  logic        fsm_state;
`ifdef IFU_FQ_PERF_EN
  logic [31:0] perf_full_cycles;
  logic [31:0] perf_flushes;
`endif

  int tests;
  int fails;
  logic [31:0] held_pc;

  ifu_fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .int_req        (int_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_pc       (fetch_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_exc        (out_exc),
    .count          (count),
    .fsm_state      (fsm_state)
`ifdef IFU_FQ_PERF_EN
    ,
    .perf_full_cycles (perf_full_cycles),
    .perf_flushes     (perf_flushes)
`endif
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    int_req = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;

    // Reset state.
    tick();
    tick();
    check("rst_fetch_pc", fetch_pc, 32'h3000);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_exc", {27'd0, out_exc}, 32'd0);
    check("rst_state", {31'd0, fsm_state}, 32'd0);

    // Streaming with out_ready=1.
    reset = 1'b0;
    check("c1_fetch_pc", fetch_pc, 32'h3000);
    check("c1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("c2_valid", {31'd0, out_valid}, 32'd1);
    check("c2_out_pc", out_pc, 32'h3000);
    check("c2_out_exc", {27'd0, out_exc}, 32'd0);
    check("c2_count", {29'd0, count}, 32'd1);
    check("c2_fetch_pc", fetch_pc, 32'h3004);
    tick();
    check("c3_out_pc", out_pc, 32'h3004);
    tick();
    check("c4_out_pc", out_pc, 32'h3008);
    check("c4_fetch_pc", fetch_pc, 32'h300c);

    // Stall from reset: fill, freeze, then drain in order.
    reset = 1'b1;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("stall_count", {29'd0, count}, 32'd4);
    check("stall_fetch_pc", fetch_pc, 32'h3010);
    for (int i = 0; i < 6; i++) tick();
    check("frozen_count", {29'd0, count}, 32'd4);
    check("frozen_fetch_pc", fetch_pc, 32'h3010);
    check("frozen_head", out_pc, 32'h3000);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("drain_head", out_pc, 32'h3000 + 32'(4 * i));
      check("drain_count", {29'd0, count}, 32'd4);
    end
    check("drain_fetch_pc", fetch_pc, 32'h3020);

    // Misaligned redirect enters FAULT; interrupt recovers.
    redirect_valid = 1'b1;
    redirect_pc = 32'h3002;
    out_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid", {31'd0, out_valid}, 32'd0);
    check("redir_count", {29'd0, count}, 32'd0);
    check("redir_fetch_pc", fetch_pc, 32'h3002);
    tick();
    check("fault_valid", {31'd0, out_valid}, 32'd1);
    check("fault_head", out_pc, 32'h3002);
    check("fault_exc", {27'd0, out_exc}, 32'h4);
    check("fault_count", {29'd0, count}, 32'd1);
    check("fault_state", {31'd0, fsm_state}, 32'd1);
    held_pc = fetch_pc;
    for (int i = 0; i < 3; i++) tick();
    check("fault_count_hold", {29'd0, count}, 32'd1);
    check("fault_fetch_hold", fetch_pc, held_pc);
    out_ready = 1'b1;
    tick();
    check("fault_drained_valid", {31'd0, out_valid}, 32'd0);
    check("fault_drained_count", {29'd0, count}, 32'd0);
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    check("int_fetch_pc", fetch_pc, 32'h4180);
    check("int_state", {31'd0, fsm_state}, 32'd0);
    tick();
    check("int_head", out_pc, 32'h4180);
    check("int_exc", {27'd0, out_exc}, 32'd0);

    // Upper address boundary.
    redirect_valid = 1'b1;
    redirect_pc = 32'h6ff0;
    tick();
    redirect_valid = 1'b0;
    check("hi_fetch_pc", fetch_pc, 32'h6ff0);
    tick();
    check("hi_head0", out_pc, 32'h6ff0);
    tick();
    check("hi_head1", out_pc, 32'h6ff4);
    tick();
    check("hi_head2", out_pc, 32'h6ff8);
    tick();
    check("hi_last_ok", out_pc, 32'h6ffc);
    check("hi_last_ok_exc", {27'd0, out_exc}, 32'd0);
    tick();
    check("hi_over", out_pc, 32'h7000);
    check("hi_over_exc", {27'd0, out_exc}, 32'h4);
    check("hi_over_state", {31'd0, fsm_state}, 32'd1);
    tick();
    check("hi_empty_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("hi_empty_count", {29'd0, count}, 32'd0);

    // Interrupt beats redirect, with a pop while full.
    redirect_valid = 1'b1;
    redirect_pc = 32'h3000;
    out_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("prio_full", {29'd0, count}, 32'd4);
    int_req = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h5000;
    out_ready = 1'b1;
    tick();
    int_req = 1'b0;
    redirect_valid = 1'b0;
    check("prio_fetch_pc", fetch_pc, 32'h4180);
    check("prio_count", {29'd0, count}, 32'd0);
    check("prio_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("prio_head0", out_pc, 32'h4180);
    tick();
    check("prio_head1", out_pc, 32'h4184);

`ifdef IFU_FQ_PERF_EN
    // Performance counters: 5 full-stall cycles, 2 flushes, then reset.
    reset = 1'b1;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("perf_fill", perf_full_cycles, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3000;
    tick();
    redirect_pc = 32'h3100;
    tick();
    redirect_valid = 1'b0;
    check("perf_full_cycles", perf_full_cycles, 32'd5);
    check("perf_flushes", perf_flushes, 32'd2);
    reset = 1'b1;
    tick();
    check("perf_full_rst", perf_full_cycles, 32'd0);
    check("perf_flushes_rst", perf_flushes, 32'd0);
    reset = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
